// File: rtl/empty_ptr_alloc_ctrl.sv
// Sole master of the empty pointer storage: reset/fill at start-up, then round-robin alloc/free for CLIENTS_CNT engines.
// Latency: alloc_gnt/free_ack one cycle after the winning request; the storage pop strobe is combinational in the request cycle.
// Backpressure: level requests wait until granted; empty storage still grants with alloc_ptr_val=0; a free into full storage is acked with free_overflow.
module empty_ptr_alloc_ctrl #(
    parameter int A_WIDTH      = 3,
    parameter int CLIENTS_CNT  = 2,
    parameter int INIT_PTR_CNT = 2**A_WIDTH
) (
    input  logic                           clk,
    input  logic                           srst,
    output logic                           init_done,
    input  logic [CLIENTS_CNT-1:0]         alloc_req,
    output logic [CLIENTS_CNT-1:0]         alloc_gnt,
    output logic [A_WIDTH-1:0]             alloc_ptr,
    output logic                           alloc_ptr_val,
    input  logic [CLIENTS_CNT-1:0]         free_req,
    input  logic [CLIENTS_CNT*A_WIDTH-1:0] free_ptr,
    output logic [CLIENTS_CNT-1:0]         free_ack,
    output logic [A_WIDTH:0]               free_cnt,
    output logic                           free_overflow,
    output logic                           eps_srst,
    output logic [A_WIDTH-1:0]             eps_add_empty_ptr,
    output logic                           eps_add_empty_ptr_en,
    output logic                           eps_next_empty_ptr_rd_ack,
    input  logic [A_WIDTH-1:0]             eps_next_empty_ptr,
    input  logic                           eps_next_empty_ptr_val
);

    localparam int CW = (CLIENTS_CNT > 1) ? $clog2(CLIENTS_CNT) : 1;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [A_WIDTH:0] INIT_LAST = (A_WIDTH+1)'(INIT_PTR_CNT - 1);
    localparam logic [A_WIDTH:0] FULL_CNT  = (A_WIDTH+1)'(INIT_PTR_CNT);

    logic [1:0]         state;
    logic [A_WIDTH:0]   init_cnt;
    logic [CW-1:0]      a_prio;
    logic [CW-1:0]      f_prio;

    logic               run;
    logic               a_vld;
    logic [CW-1:0]      a_win;
    logic               f_vld;
    logic [CW-1:0]      f_win;
    logic               a_fire;
    logic               pop;
    logic               f_fire;
    logic               f_ovf;
    logic               f_push;
    logic [A_WIDTH-1:0] f_ptr;

    // Winner is the eligible client at the smallest circular distance from prio.
    function automatic logic [CW:0] rr_pick(input logic [CLIENTS_CNT-1:0] elig,
                                            input logic [CW-1:0]          prio);
        logic          found;
        logic [CW-1:0] win;
        int            d;
        int            best;
        found = 1'b0;
        win   = '0;
        best  = 0;
        for (int i = 0; i < CLIENTS_CNT; i++) begin
            if (elig[i]) begin
                d = (i >= int'(prio)) ? (i - int'(prio)) : (i + CLIENTS_CNT - int'(prio));
                if (!found || d < best) begin
                    found = 1'b1;
                    best  = d;
                    win   = CW'(i);
                end
            end
        end
        return {found, win};
    endfunction

    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] w);
        if (int'(w) >= CLIENTS_CNT - 1)
            return '0;
        return w + 1'b1;
    endfunction

    // Clients whose gnt/ack is visible this cycle are masked while their request drops.
    always_comb begin
        run            = init_done && !srst;
        {a_vld, a_win} = rr_pick(alloc_req & ~alloc_gnt, a_prio);
        {f_vld, f_win} = rr_pick(free_req & ~free_ack, f_prio);
        a_fire         = run && a_vld;
        pop            = a_fire && eps_next_empty_ptr_val;
        f_fire         = run && f_vld;
        f_ovf          = f_fire && (free_cnt == FULL_CNT) && !pop;
        f_push         = f_fire && !f_ovf;
        f_ptr          = '0;
        for (int i = 0; i < CLIENTS_CNT; i++) begin
            if (int'(f_win) == i)
                f_ptr = free_ptr[i*A_WIDTH +: A_WIDTH];
        end
    end

    assign eps_next_empty_ptr_rd_ack = pop;

    always_ff @(posedge clk) begin
        if (srst) begin
            state                <= ST_RST;
            init_cnt             <= '0;
            a_prio               <= '0;
            f_prio               <= '0;
            init_done            <= 1'b0;
            alloc_gnt            <= '0;
            alloc_ptr            <= '0;
            alloc_ptr_val        <= 1'b0;
            free_ack             <= '0;
            free_cnt             <= '0;
            free_overflow        <= 1'b0;
            eps_srst             <= 1'b0;
            eps_add_empty_ptr    <= '0;
            eps_add_empty_ptr_en <= 1'b0;
        end else begin
            alloc_gnt            <= a_fire ? (CLIENTS_CNT'(1) << a_win) : '0;
            alloc_ptr            <= pop ? eps_next_empty_ptr : '0;
            alloc_ptr_val        <= pop;
            free_ack             <= f_fire ? (CLIENTS_CNT'(1) << f_win) : '0;
            free_overflow        <= f_ovf;
            eps_srst             <= 1'b0;
            eps_add_empty_ptr_en <= f_push;
            eps_add_empty_ptr    <= f_push ? f_ptr : '0;
            if (a_fire)
                a_prio <= rr_next(a_win);
            if (f_fire)
                f_prio <= rr_next(f_win);
            // Count tracks committed pushes, so back-to-back frees see an accurate fill level.
            case ({f_push, pop})
                2'b10:   free_cnt <= free_cnt + 1'b1;
                2'b01:   free_cnt <= free_cnt - 1'b1;
                default: ;
            endcase

            case (state)
                ST_RST: begin
                    eps_srst <= 1'b1;
                    state    <= ST_INIT;
                end
                ST_INIT: begin
                    eps_add_empty_ptr_en <= 1'b1;
                    eps_add_empty_ptr    <= init_cnt[A_WIDTH-1:0];
                    free_cnt             <= free_cnt + 1'b1;
                    init_cnt             <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_empty_ptr_alloc_ctrl.sv
// Bench for empty_ptr_alloc_ctrl: show-ahead storage model, vector table, corner sequences and a random run
// checked against a queue-based reference of the pointer pool.
module tb_empty_ptr_alloc_ctrl;

    localparam int AW = 3;
    localparam int NC = 2;
    localparam int NP = 8;

    logic            clk = 1'b0;
    logic            srst = 1'b1;
    logic            init_done;
    logic [NC-1:0]   alloc_req = '0;
    logic [NC-1:0]   alloc_gnt;
    logic [AW-1:0]   alloc_ptr;
    logic            alloc_ptr_val;
    logic [NC-1:0]   free_req = '0;
    logic [NC*AW-1:0] free_ptr = '0;
    logic [NC-1:0]   free_ack;
    logic [AW:0]     free_cnt;
    logic            free_overflow;
    logic            eps_srst;
    logic [AW-1:0]   eps_add_empty_ptr;
    logic            eps_add_empty_ptr_en;
    logic            eps_next_empty_ptr_rd_ack;
    logic [AW-1:0]   eps_next_empty_ptr = '0;
    logic            eps_next_empty_ptr_val = 1'b0;

    always #5 clk = ~clk;

    empty_ptr_alloc_ctrl #(.A_WIDTH(AW), .CLIENTS_CNT(NC), .INIT_PTR_CNT(NP)) dut (
        .clk                       (clk),
        .srst                      (srst),
        .init_done                 (init_done),
        .alloc_req                 (alloc_req),
        .alloc_gnt                 (alloc_gnt),
        .alloc_ptr                 (alloc_ptr),
        .alloc_ptr_val             (alloc_ptr_val),
        .free_req                  (free_req),
        .free_ptr                  (free_ptr),
        .free_ack                  (free_ack),
        .free_cnt                  (free_cnt),
        .free_overflow             (free_overflow),
        .eps_srst                  (eps_srst),
        .eps_add_empty_ptr         (eps_add_empty_ptr),
        .eps_add_empty_ptr_en      (eps_add_empty_ptr_en),
        .eps_next_empty_ptr_rd_ack (eps_next_empty_ptr_rd_ack),
        .eps_next_empty_ptr        (eps_next_empty_ptr),
        .eps_next_empty_ptr_val    (eps_next_empty_ptr_val)
    );

    // Show-ahead storage: pushes become visible at the head one cycle after they are latched.
    logic [AW-1:0] sq[$];
    always @(posedge clk) begin
        if (eps_srst) begin
            sq.delete();
        end else begin
            if (eps_next_empty_ptr_rd_ack && sq.size() > 0)
                void'(sq.pop_front());
            if (eps_add_empty_ptr_en)
                sq.push_back(eps_add_empty_ptr);
        end
        eps_next_empty_ptr     <= (sq.size() > 0) ? sq[0] : '0;
        eps_next_empty_ptr_val <= (sq.size() > 0);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst      = 1'b1;
        alloc_req = '0;
        free_req  = '0;
        repeat (3) @(negedge clk);
        chk("rst_eps_srst", eps_srst, 0);
        chk("rst_push_en", eps_add_empty_ptr_en, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_ack", free_ack, 0);
        chk("rst_free_cnt", free_cnt, 0);
        chk("rst_ovf", free_overflow, 0);
        chk("rst_rd_ack", eps_next_empty_ptr_rd_ack, 0);
        srst = 1'b0;
    endtask

    // Cycle 1 after release: storage reset; cycles 2..9: pushes 0..7; cycle 10: init_done.
    task automatic check_init(input int upto);
        for (int c = 1; c <= upto; c++) begin
            @(negedge clk);
            chk("init_eps_srst", eps_srst, (c == 1));
            chk("init_push_en", eps_add_empty_ptr_en, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9)
                chk("init_push_ptr", eps_add_empty_ptr, c - 2);
            chk("init_free_cnt", free_cnt, (c == 1) ? 0 : ((c <= 9) ? c - 1 : NP));
            chk("init_done", init_done, (c == 10));
            chk("init_no_gnt", alloc_gnt, 0);
        end
    endtask

    typedef struct {
        logic [1:0] areq;
        logic [1:0] freq;
        logic [2:0] fp0;
        logic [2:0] fp1;
        logic       rd;
        logic [1:0] gnt;
        logic       val;
        logic [2:0] ptr;
        logic [1:0] ack;
        logic       push;
        logic [2:0] pptr;
        logic       ovf;
        logic [3:0] cnt;
    } vec_t;

    vec_t vt[10];
    int   exh[5];

    // Reference model state for the random run.
    logic [AW-1:0] mq[$];
    int            mcnt, aprio, fprio, awin, fwin;
    logic [1:0]    e_gnt, e_ack;
    logic          e_val, e_push, e_ovf, cur_push, m_pop, m_ovf, m_push;
    logic [2:0]    e_ptr, e_pptr, cur_pptr;

    initial begin
        //          areq   freq   fp0   fp1  rd    gnt    val   ptr   ack    push  pptr  ovf   cnt
        vt[0] = '{2'b00, 2'b01, 3'd2, 3'd0, 1'b0, 2'b00, 1'b0, 3'd0, 2'b01, 1'b0, 3'd0, 1'b1, 4'd8};
        vt[1] = '{2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 2'b01, 1'b1, 3'd0, 2'b00, 1'b0, 3'd0, 1'b0, 4'd7};
        vt[2] = '{2'b10, 2'b00, 3'd0, 3'd0, 1'b1, 2'b10, 1'b1, 3'd1, 2'b00, 1'b0, 3'd0, 1'b0, 4'd6};
        vt[3] = '{2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 2'b01, 1'b1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0, 4'd5};
        vt[4] = '{2'b10, 2'b00, 3'd0, 3'd0, 1'b1, 2'b10, 1'b1, 3'd3, 2'b00, 1'b0, 3'd0, 1'b0, 4'd4};
        vt[5] = '{2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 2'b01, 1'b1, 3'd4, 2'b00, 1'b0, 3'd0, 1'b0, 4'd3};
        vt[6] = '{2'b10, 2'b01, 3'd3, 3'd0, 1'b1, 2'b10, 1'b1, 3'd5, 2'b01, 1'b1, 3'd3, 1'b0, 4'd3};
        vt[7] = '{2'b00, 2'b11, 3'd0, 3'd1, 1'b0, 2'b00, 1'b0, 3'd0, 2'b10, 1'b1, 3'd1, 1'b0, 4'd4};
        vt[8] = '{2'b00, 2'b11, 3'd0, 3'd4, 1'b0, 2'b00, 1'b0, 3'd0, 2'b01, 1'b1, 3'd0, 1'b0, 4'd5};
        vt[9] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00, 1'b0, 3'd0, 1'b0, 4'd5};
        exh = '{6, 7, 3, 1, 0};

        do_reset();
        check_init(10);

        // Overflow, round-robin alloc, concurrent free+alloc, free round-robin.
        for (int i = 0; i < 10; i++) begin
            alloc_req = vt[i].areq;
            free_req  = vt[i].freq;
            free_ptr  = {vt[i].fp1, vt[i].fp0};
            #1;
            chk("tbl_rd_ack", eps_next_empty_ptr_rd_ack, vt[i].rd);
            @(negedge clk);
            chk("tbl_gnt", alloc_gnt, vt[i].gnt);
            chk("tbl_val", alloc_ptr_val, vt[i].val);
            chk("tbl_ptr", alloc_ptr, vt[i].ptr);
            chk("tbl_ack", free_ack, vt[i].ack);
            chk("tbl_push_en", eps_add_empty_ptr_en, vt[i].push);
            chk("tbl_push_ptr", eps_add_empty_ptr, vt[i].pptr);
            chk("tbl_ovf", free_overflow, vt[i].ovf);
            chk("tbl_free_cnt", free_cnt, vt[i].cnt);
        end

        // Exhaustion: five remaining pointers, then an empty grant without a pop.
        for (int k = 0; k < 6; k++) begin
            alloc_req = 2'b01;
            free_req  = 2'b00;
            #1;
            chk("exh_rd_ack", eps_next_empty_ptr_rd_ack, (k < 5));
            @(negedge clk);
            chk("exh_gnt", alloc_gnt, 2'b01);
            chk("exh_val", alloc_ptr_val, (k < 5));
            chk("exh_ptr", alloc_ptr, (k < 5) ? exh[k] : 0);
            chk("exh_free_cnt", free_cnt, (k < 5) ? 4 - k : 0);
            alloc_req = 2'b00;
            @(negedge clk);
        end

        // Free into empty storage alongside an alloc: the freed pointer is not yet visible.
        alloc_req = 2'b01;
        free_req  = 2'b10;
        free_ptr  = {3'd6, 3'd0};
        #1;
        chk("emp_rd_ack", eps_next_empty_ptr_rd_ack, 0);
        @(negedge clk);
        chk("emp_gnt", alloc_gnt, 2'b01);
        chk("emp_val", alloc_ptr_val, 0);
        chk("emp_ack", free_ack, 2'b10);
        chk("emp_push_ptr", eps_add_empty_ptr, 6);
        chk("emp_free_cnt", free_cnt, 1);
        alloc_req = 2'b10;
        free_req  = 2'b00;
        #1;
        chk("emp_latch_rd_ack", eps_next_empty_ptr_rd_ack, 0);
        @(negedge clk);
        chk("emp_latch_val", alloc_ptr_val, 0);
        alloc_req = 2'b01;
        #1;
        chk("emp_vis_rd_ack", eps_next_empty_ptr_rd_ack, 1);
        @(negedge clk);
        chk("emp_vis_val", alloc_ptr_val, 1);
        chk("emp_vis_ptr", alloc_ptr, 6);
        chk("emp_vis_free_cnt", free_cnt, 0);
        alloc_req = 2'b00;

        // Random traffic against the reference pool.
        do_reset();
        check_init(10);
        mq.delete();
        for (int v = 0; v < NP; v++) mq.push_back(AW'(v));
        mcnt = NP; aprio = 0; fprio = 0;
        e_gnt = '0; e_ack = '0; e_val = 0; e_push = 0; e_ovf = 0; e_ptr = '0; e_pptr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_gnt", alloc_gnt, e_gnt);
            chk("rnd_val", alloc_ptr_val, e_val);
            chk("rnd_ptr", alloc_ptr, e_ptr);
            chk("rnd_ack", free_ack, e_ack);
            chk("rnd_push_en", eps_add_empty_ptr_en, e_push);
            chk("rnd_push_ptr", eps_add_empty_ptr, e_pptr);
            chk("rnd_ovf", free_overflow, e_ovf);
            chk("rnd_free_cnt", free_cnt, mcnt);
            for (int i = 0; i < NC; i++) begin
                if (alloc_req[i] && e_gnt[i])
                    alloc_req[i] = ($urandom_range(0, 3) == 0);
                else if (!alloc_req[i])
                    alloc_req[i] = ($urandom_range(0, 1) == 1);
                if ((free_req[i] && e_ack[i]) || !free_req[i]) begin
                    free_req[i] = ($urandom_range(0, 1) == 1);
                    free_ptr[i*AW +: AW] = AW'($urandom_range(0, NP - 1));
                end
            end
            cur_push = e_push;
            cur_pptr = e_pptr;
            awin = -1;
            fwin = -1;
            for (int k = 0; k < NC; k++) begin
                if (awin < 0 && alloc_req[(aprio + k) % NC] && !e_gnt[(aprio + k) % NC])
                    awin = (aprio + k) % NC;
                if (fwin < 0 && free_req[(fprio + k) % NC] && !e_ack[(fprio + k) % NC])
                    fwin = (fprio + k) % NC;
            end
            m_pop  = (awin >= 0) && (mq.size() > 0);
            m_ovf  = (fwin >= 0) && (mcnt == NP) && !m_pop;
            m_push = (fwin >= 0) && !m_ovf;
            #1;
            chk("rnd_rd_ack", eps_next_empty_ptr_rd_ack, m_pop);
            e_gnt  = (awin >= 0) ? (2'b01 << awin) : 2'b00;
            e_val  = m_pop;
            e_ptr  = m_pop ? mq[0] : 3'd0;
            e_ack  = (fwin >= 0) ? (2'b01 << fwin) : 2'b00;
            e_ovf  = m_ovf;
            e_push = m_push;
            e_pptr = m_push ? free_ptr[fwin*AW +: AW] : 3'd0;
            if (awin >= 0) aprio = (awin + 1) % NC;
            if (fwin >= 0) fprio = (fwin + 1) % NC;
            if (m_pop) void'(mq.pop_front());
            if (cur_push) mq.push_back(cur_pptr);
            mcnt = mcnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            @(negedge clk);
        end

        // Reset in the middle of init, with an alloc request waiting throughout.
        srst      = 1'b1;
        alloc_req = 2'b01;
        free_req  = 2'b00;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        check_init(5);
        srst = 1'b1;
        @(negedge clk);
        chk("mid_rst_push_en", eps_add_empty_ptr_en, 0);
        chk("mid_rst_free_cnt", free_cnt, 0);
        chk("mid_rst_eps_srst", eps_srst, 0);
        chk("mid_rst_gnt", alloc_gnt, 0);
        srst = 1'b0;
        check_init(10);
        @(negedge clk);
        chk("mid_first_gnt", alloc_gnt, 2'b01);
        chk("mid_first_val", alloc_ptr_val, 1);
        chk("mid_first_ptr", alloc_ptr, 0);
        chk("mid_first_free_cnt", free_cnt, 7);
        alloc_req = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected end before t=1000000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/empty_ptr_alloc_ctrl.md
Name: empty_ptr_alloc_ctrl

Overview:
- Sole master of the empty pointer storage (`empty_ptr_storage` slave: srst, add_empty_ptr/_en, next_empty_ptr_rd_ack, next_empty_ptr/_val).
- After reset it clears the storage and fills it with every table address.
- In run mode it shares the storage between CLIENTS_CNT hash-table engines. Each engine allocates pointers on insert and frees them on delete.
- Alloc and free paths each use their own round-robin arbiter. The block also keeps a free-pointer count.

Parameters:
- A_WIDTH, hash_table::TABLE_ADDR_WIDTH, pointer width.
- CLIENTS_CNT, 2, number of requesting engines (≥1).
- INIT_PTR_CNT, 2**A_WIDTH, pointers pushed at init (values 0..INIT_PTR_CNT-1; ≤2**A_WIDTH).

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- init_done  out  1  high in RUN state.
- alloc_req  in  CLIENTS_CNT  per-client allocate request, level; held until alloc_gnt.
- alloc_gnt  out  CLIENTS_CNT  one-hot, 1-cycle pulse.
- alloc_ptr  out  A_WIDTH  allocated pointer, valid with alloc_gnt.
- alloc_ptr_val  out  1  with alloc_gnt: 1 = pointer delivered, 0 = storage empty.
- free_req  in  CLIENTS_CNT  per-client free request, level; held until free_ack.
- free_ptr  in  CLIENTS_CNT*A_WIDTH  client i pointer in bits [i*A_WIDTH +: A_WIDTH].
- free_ack  out  CLIENTS_CNT  one-hot, 1-cycle pulse.
- free_cnt  out  A_WIDTH+1  pointers currently in storage.
- free_overflow  out  1  1-cycle pulse: free rejected because free_cnt==INIT_PTR_CNT.
- eps_srst  out  1  storage reset.
- eps_add_empty_ptr  out  A_WIDTH  pointer to push.
- eps_add_empty_ptr_en  out  1  push strobe.
- eps_next_empty_ptr_rd_ack  out  1  pop strobe (show-ahead storage).
- eps_next_empty_ptr  in  A_WIDTH  head pointer.
- eps_next_empty_ptr_val  in  1  head valid.

Behaviour:
- srst high (any state, any cycle) → state ST_RST next cycle.
- Values forced by srst: all outputs 0, free_cnt=0, both RR priority pointers at client 0, init counter 0.
- Any in-flight grant, ack or push is dropped on reset; clients re-request afterwards.
- FSM:
  - ST_RST: eps_srst=1 for exactly one cycle, then ST_INIT.
  - ST_INIT: eps_add_empty_ptr_en=1 every cycle with eps_add_empty_ptr=init counter (0,1,2,…). free_cnt increments each push.
  - After pushing INIT_PTR_CNT-1, go to ST_RUN. Init lasts exactly INIT_PTR_CNT cycles.
  - ST_RUN: init_done=1. Stays in ST_RUN until srst.
- Requests arriving in ST_RST or ST_INIT are not served; they wait.
- Alloc path (ST_RUN), cycle T:
  - The RR arbiter picks winner w among eligible alloc_req.
  - eps_next_empty_ptr_rd_ack = eps_next_empty_ptr_val (combinational, cycle T).
  - Cycle T+1: alloc_gnt[w]=1, alloc_ptr = head sampled at T, alloc_ptr_val = val sampled at T.
  - Empty storage: grant still issued with alloc_ptr_val=0 and no pop. alloc_ptr is don't-care but driven 0.
- Free path (ST_RUN), cycle T:
  - The RR arbiter picks winner w among eligible free_req.
  - Cycle T+1: free_ack[w]=1, eps_add_empty_ptr_en=1, eps_add_empty_ptr = free_ptr[w] sampled at T.
  - Registered outputs.
- Eligibility: a client whose gnt (resp. ack) is high this cycle is masked from that arbiter this cycle. This prevents a double grant while the request drops.
- Round-robin rule: priority starts at the client after the last winner. The pointer updates only on a win. Alloc and free pointers are independent.
- Throughput: up to one alloc and one free per cycle, concurrently. The same client may win both in one cycle.
- free_cnt:
  - +1 on each push.
  - -1 on each pop (rd_ack with val).
  - Push and pop in the same cycle: unchanged.
- A freed pointer becomes visible to alloc only after the storage latches the push. An alloc against empty storage in the same cycle as a free returns alloc_ptr_val=0.
- Overflow: a free winner at T while free_cnt==INIT_PTR_CNT (no pop at T) gives:
  - T+1: free_ack[w]=1 and free_overflow=1.
  - No push; free_cnt unchanged.

Test Plan (A_WIDTH=3, INIT_PTR_CNT=8, CLIENTS_CNT=2):
- Init sequence: deassert srst → eps_srst pulse 1 cycle, then 8 pushes of 0..7 on consecutive cycles. init_done rises the cycle after pushing 7; free_cnt=8.
- Alloc round-robin: alloc_req=2'b11 held, each client drops on its gnt → grants client0 (ptr per storage head, val=1), then client1. Exactly one pop per grant; free_cnt 8→6.
- Exhaustion: 8 allocs, then a 9th request → alloc_gnt with alloc_ptr_val=0, no rd_ack, free_cnt stays 0.
- Free plus concurrent alloc: free_cnt=3, client0 frees ptr 5 while client1 allocates in the same cycle → free_ack[0] and alloc_gnt[1] both at T+1; push of 5; free_cnt stays 3.
- Overflow: free ptr 2 with free_cnt=8 → free_ack and free_overflow pulse, no eps_add_empty_ptr_en, free_cnt=8.
- Mid-init reset: srst asserted after 4 init pushes → outputs cleared, then eps_srst pulse and a full 0..7 re-init. No alloc_gnt before init_done.
